// File: rtl/pl_pkg.sv
// Shared definitions for the EX/MEM pipeline boundary: branch-condition
// encodings, default widths and status-flag bit positions.
package pl_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 16;
  localparam int RD_W_DEF   = 3;

  typedef enum logic [1:0] {
    BR_ALWAYS = 2'b00,
    BR_EQ     = 2'b01,
    BR_GT     = 2'b10,
    BR_LT     = 2'b11
  } br_cond_e;

  // Bit positions inside the packed {C, GT, LT, EQ} flag vector.
  localparam int FLAG_C  = 3;
  localparam int FLAG_GT = 2;
  localparam int FLAG_LT = 1;
  localparam int FLAG_EQ = 0;

endpackage

// File: rtl/pl_branch_cond.sv
// Branch condition evaluator: decides from the committed status flags
// whether a jump with the given condition code is taken.
module pl_branch_cond
  import pl_pkg::*;
(
  input  logic [1:0] cond,
  input  logic [3:0] flags,
  output logic       taken
);

  // Carry never participates in a branch condition.
  logic unused_flag_c;
  assign unused_flag_c = flags[FLAG_C];

  // Select the flag that the condition code names.
  always_comb begin
    // NOTE: default first so no path through the case can infer a latch.
    taken = 1'b0;
    case (br_cond_e'(cond))
      BR_ALWAYS: taken = 1'b1;
      BR_EQ:     taken = flags[FLAG_EQ];
      BR_GT:     taken = flags[FLAG_GT];
      BR_LT:     taken = flags[FLAG_LT];
      default:   taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/pl_exmem_stage.sv
// EX/MEM boundary stage: registers the EX instruction into MEM under a
// valid/ready handshake, owns the C/GT/LT/EQ status flags, resolves jumps
// against them, squashes the instruction following a taken branch and
// provides a forwarding tap back to EX.
module pl_exmem_stage
  import pl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int RD_W   = RD_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [DATA_W-1:0] alu_dout,
  input  logic              alu_cout,
  input  logic              comp_gt,
  input  logic              comp_lt,
  input  logic              comp_eq,
  input  logic              ex_upd_c,
  input  logic              ex_cmp,
  input  logic              ex_jump,
  input  logic [1:0]        ex_br_cond,
  input  logic [ADDR_W-1:0] ex_br_target,
  input  logic              ex_wb_en,
  input  logic              ex_mem_we,
  input  logic              ex_mem_re,
  input  logic [RD_W-1:0]   ex_rd,
  input  logic [ADDR_W-1:0] ex_mem_addr,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic              mem_ready,
  output logic              mem_valid,
  output logic [DATA_W-1:0] mem_dout,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic              mem_re,
  output logic              mem_wb_en,
  output logic [RD_W-1:0]   mem_rd,
  output logic              flag_c,
  output logic              flag_gt,
  output logic              flag_lt,
  output logic              flag_eq,
  output logic              br_taken,
  output logic [ADDR_W-1:0] br_target,
  output logic              flush_out,
  output logic              fwd_valid,
  output logic [RD_W-1:0]   fwd_rd,
  output logic [DATA_W-1:0] fwd_data
);

  logic              mem_valid_q, mem_valid_d;
  logic [DATA_W-1:0] mem_dout_q, mem_wdata_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              mem_we_q, mem_re_q, mem_wb_en_q;
  logic [RD_W-1:0]   mem_rd_q;
  logic [3:0]        flags_q;
  logic              br_taken_q;
  logic [ADDR_W-1:0] br_target_q;
  logic              squash_q, squash_d;

  logic hs, acc, drop, cond_taken, take_branch;

  assign ex_ready    = !mem_valid_q || mem_ready;
  assign hs          = ex_valid && ex_ready;
  assign acc         = hs && !squash_q;
  assign drop        = hs && squash_q;
  // The condition sees the flags as they were before this cycle's update.
  assign take_branch = acc && ex_jump && cond_taken;

  pl_branch_cond u_branch_cond (
    .cond  (ex_br_cond),
    .flags (flags_q),
    .taken (cond_taken)
  );

  // Next-state for the MEM valid bit and the post-branch squash marker.
  always_comb begin
    mem_valid_d = mem_valid_q;
    if (acc)                    mem_valid_d = !ex_jump;
    else if (drop || mem_ready) mem_valid_d = 1'b0;

    squash_d = squash_q;
    if (take_branch) squash_d = 1'b1;
    else if (drop)   squash_d = 1'b0;
  end

  // Pipeline register into MEM; payload loads only on an accepted instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_valid_q <= 1'b0;
      mem_dout_q  <= '0;
      mem_wdata_q <= '0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_wb_en_q <= 1'b0;
      mem_rd_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      mem_valid_q <= mem_valid_d;
      if (acc) begin
        mem_dout_q  <= alu_dout;
        mem_wdata_q <= ex_store_data;
        mem_addr_q  <= ex_mem_addr;
        mem_we_q    <= ex_mem_we;
        mem_re_q    <= ex_mem_re;
        mem_wb_en_q <= ex_wb_en;
        mem_rd_q    <= ex_rd;
      end
    end
  end

  // Status flags: carry and compare groups update independently on acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
    end else if (acc) begin
      if (ex_upd_c) flags_q[FLAG_C] <= alu_cout;
      if (ex_cmp) begin
        flags_q[FLAG_GT] <= comp_gt;
        flags_q[FLAG_LT] <= comp_lt;
        flags_q[FLAG_EQ] <= comp_eq;
      end
    end
  end

  // Branch pulse, held target, and squash of the instruction after a taken branch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_taken_q  <= 1'b0;
      br_target_q <= '0;
      squash_q    <= 1'b0;
    end else begin
      br_taken_q <= take_branch;
      squash_q   <= squash_d;
      if (take_branch) br_target_q <= ex_br_target;
    end
  end

  assign mem_valid = mem_valid_q;
  assign mem_dout  = mem_dout_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_re    = mem_re_q;
  assign mem_wb_en = mem_wb_en_q;
  assign mem_rd    = mem_rd_q;
  assign flag_c    = flags_q[FLAG_C];
  assign flag_gt   = flags_q[FLAG_GT];
  assign flag_lt   = flags_q[FLAG_LT];
  assign flag_eq   = flags_q[FLAG_EQ];
  assign br_taken  = br_taken_q;
  assign br_target = br_target_q;
  assign flush_out = br_taken_q;
  assign fwd_valid = mem_valid_q && mem_wb_en_q;
  assign fwd_rd    = mem_rd_q;
  assign fwd_data  = mem_dout_q;

endmodule

// File: tb/tb_pl_exmem_stage.sv
// Directed bench for pl_exmem_stage: each task drives one scenario and
// compares outputs against hand-computed values.
module tb_pl_exmem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_ready;
  logic [7:0]  alu_dout;
  logic        alu_cout, comp_gt, comp_lt, comp_eq;
  logic        ex_upd_c, ex_cmp, ex_jump;
  logic [1:0]  ex_br_cond;
  logic [15:0] ex_br_target;
  logic        ex_wb_en, ex_mem_we, ex_mem_re;
  logic [2:0]  ex_rd;
  logic [15:0] ex_mem_addr;
  logic [7:0]  ex_store_data;
  logic        mem_ready, mem_valid;
  logic [7:0]  mem_dout, mem_wdata;
  logic [15:0] mem_addr;
  logic        mem_we, mem_re, mem_wb_en;
  logic [2:0]  mem_rd;
  logic        flag_c, flag_gt, flag_lt, flag_eq;
  logic        br_taken;
  logic [15:0] br_target;
  logic        flush_out, fwd_valid;
  logic [2:0]  fwd_rd;
  logic [7:0]  fwd_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pl_exmem_stage dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .alu_dout(alu_dout), .alu_cout(alu_cout), .comp_gt(comp_gt),
    .comp_lt(comp_lt), .comp_eq(comp_eq), .ex_upd_c(ex_upd_c),
    .ex_cmp(ex_cmp), .ex_jump(ex_jump), .ex_br_cond(ex_br_cond),
    .ex_br_target(ex_br_target), .ex_wb_en(ex_wb_en), .ex_mem_we(ex_mem_we),
    .ex_mem_re(ex_mem_re), .ex_rd(ex_rd), .ex_mem_addr(ex_mem_addr),
    .ex_store_data(ex_store_data), .mem_ready(mem_ready), .mem_valid(mem_valid),
    .mem_dout(mem_dout), .mem_wdata(mem_wdata), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_re(mem_re), .mem_wb_en(mem_wb_en), .mem_rd(mem_rd),
    .flag_c(flag_c), .flag_gt(flag_gt), .flag_lt(flag_lt), .flag_eq(flag_eq),
    .br_taken(br_taken), .br_target(br_target), .flush_out(flush_out),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
  );

  // Clear every EX-side input; mem_ready is left to the caller.
  task automatic idle();
    ex_valid = 0; alu_dout = '0; alu_cout = 0; comp_gt = 0; comp_lt = 0;
    comp_eq = 0; ex_upd_c = 0; ex_cmp = 0; ex_jump = 0; ex_br_cond = '0;
    ex_br_target = '0; ex_wb_en = 0; ex_mem_we = 0; ex_mem_re = 0;
    ex_rd = '0; ex_mem_addr = '0; ex_store_data = '0;
  endtask

  // Advance one clock; outputs are then sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0; mem_ready = 1; idle();
    #12;
    total++;
    if ({mem_valid, mem_dout, mem_wdata, mem_addr, mem_we, mem_re, mem_wb_en, mem_rd} !== '0) begin
      bad++; $display("FAIL reset_mem: got valid=%0b dout=%0h addr=%0h want all zero", mem_valid, mem_dout, mem_addr);
    end
    total++;
    if ({flag_c, flag_gt, flag_lt, flag_eq, br_taken, br_target, flush_out, fwd_valid} !== '0) begin
      bad++; $display("FAIL reset_flags_br: got flags=%b%b%b%b br=%0b tgt=%0h want zero", flag_c, flag_gt, flag_lt, flag_eq, br_taken, br_target);
    end
    @(negedge clk); rst_n = 1; #1;
    total++;
    if (ex_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %0b want 1", ex_ready); end
  endtask

  task automatic test_cmp_branch();
    // Compare setting GT.
    idle(); ex_valid = 1; ex_cmp = 1; comp_gt = 1; alu_dout = 8'h10;
    step();
    total++;
    if ({mem_valid, mem_dout, flag_gt, flag_lt, flag_eq} !== {1'b1, 8'h10, 3'b100}) begin
      bad++; $display("FAIL cmp_accept: got v=%0b d=%0h gle=%b%b%b want v=1 d=10 gle=100", mem_valid, mem_dout, flag_gt, flag_lt, flag_eq);
    end
    // Jump on GT, taken.
    idle(); ex_valid = 1; ex_jump = 1; ex_br_cond = 2'b10; ex_br_target = 16'h1234;
    step();
    total++;
    if ({br_taken, flush_out, br_target, mem_valid} !== {1'b1, 1'b1, 16'h1234, 1'b0}) begin
      bad++; $display("FAIL br_gt_taken: got br=%0b fl=%0b tgt=%0h v=%0b want br=1 fl=1 tgt=1234 v=0", br_taken, flush_out, br_target, mem_valid);
    end
    // Next instruction is dropped: it would set LT and C if accepted.
    idle(); ex_valid = 1; ex_cmp = 1; comp_lt = 1; ex_upd_c = 1; alu_cout = 1;
    alu_dout = 8'h77; ex_wb_en = 1;
    #1;
    total++;
    if (ex_ready !== 1'b1) begin bad++; $display("FAIL drop_ready: got %0b want 1", ex_ready); end
    step();
    total++;
    if ({br_taken, flush_out, mem_valid, flag_c, flag_gt, flag_lt} !== {5'b00001, 1'b0}) begin
      bad++; $display("FAIL drop_effects: got br=%0b fl=%0b v=%0b c=%0b gt=%0b lt=%0b want br=0 fl=0 v=0 c=0 gt=1 lt=0", br_taken, flush_out, mem_valid, flag_c, flag_gt, flag_lt);
    end
    // Squash consumed; the following instruction is accepted.
    idle(); ex_valid = 1; alu_dout = 8'h33;
    step();
    total++;
    if ({mem_valid, mem_dout} !== {1'b1, 8'h33}) begin
      bad++; $display("FAIL after_drop: got v=%0b d=%0h want v=1 d=33", mem_valid, mem_dout);
    end
  endtask

  task automatic test_same_cycle();
    // cmp sets EQ while jumping on EQ; the jump sees the old EQ=0.
    idle(); ex_valid = 1; ex_cmp = 1; comp_eq = 1; ex_jump = 1; ex_br_cond = 2'b01;
    ex_br_target = 16'h0F00;
    step();
    total++;
    if ({br_taken, mem_valid, flag_gt, flag_lt, flag_eq} !== 5'b00001) begin
      bad++; $display("FAIL same_cycle: got br=%0b v=%0b gle=%b%b%b want br=0 v=0 gle=001", br_taken, mem_valid, flag_gt, flag_lt, flag_eq);
    end
    // EQ is now committed, so the same jump is taken.
    idle(); ex_valid = 1; ex_jump = 1; ex_br_cond = 2'b01; ex_br_target = 16'h00EE;
    step();
    total++;
    if ({br_taken, br_target} !== {1'b1, 16'h00EE}) begin
      bad++; $display("FAIL br_eq_taken: got br=%0b tgt=%0h want br=1 tgt=00ee", br_taken, br_target);
    end
    idle(); ex_valid = 1; alu_dout = 8'h99; ex_wb_en = 1;
    step();
    total++;
    if ({mem_valid, br_taken} !== 2'b00) begin
      bad++; $display("FAIL eq_drop: got v=%0b br=%0b want v=0 br=0", mem_valid, br_taken);
    end
  endtask

  task automatic test_backpressure();
    idle(); mem_ready = 1; ex_valid = 1; alu_dout = 8'h44; ex_wb_en = 1; ex_rd = 3'd2;
    step();
    mem_ready = 0;
    idle(); ex_valid = 1; alu_dout = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (ex_ready !== 1'b0) begin bad++; $display("FAIL stall_ready[%0d]: got %0b want 0", i, ex_ready); end
      step();
      total++;
      if ({mem_valid, mem_dout, mem_rd} !== {1'b1, 8'h44, 3'd2}) begin
        bad++; $display("FAIL stall_hold[%0d]: got v=%0b d=%0h rd=%0d want v=1 d=44 rd=2", i, mem_valid, mem_dout, mem_rd);
      end
    end
    mem_ready = 1;
    #1;
    total++;
    if (ex_ready !== 1'b1) begin bad++; $display("FAIL release_ready: got %0b want 1", ex_ready); end
    step();
    total++;
    if ({mem_valid, mem_dout, mem_wb_en} !== {1'b1, 8'h5A, 1'b0}) begin
      bad++; $display("FAIL release_accept: got v=%0b d=%0h wb=%0b want v=1 d=5a wb=0", mem_valid, mem_dout, mem_wb_en);
    end
    idle();
    step();
    total++;
    if (mem_valid !== 1'b0) begin bad++; $display("FAIL drain: got %0b want 0", mem_valid); end
  endtask

  task automatic test_carry_fwd();
    idle(); ex_valid = 1; ex_upd_c = 1; alu_cout = 1; alu_dout = 8'hFF; ex_wb_en = 1;
    ex_rd = 3'd5; ex_mem_we = 1; ex_mem_addr = 16'hBEEF; ex_store_data = 8'hC3;
    step();
    total++;
    if ({flag_c, fwd_valid, fwd_rd, fwd_data} !== {1'b1, 1'b1, 3'd5, 8'hFF}) begin
      bad++; $display("FAIL carry_fwd: got c=%0b fv=%0b frd=%0d fd=%0h want c=1 fv=1 frd=5 fd=ff", flag_c, fwd_valid, fwd_rd, fwd_data);
    end
    total++;
    if ({mem_we, mem_re, mem_addr, mem_wdata} !== {1'b1, 1'b0, 16'hBEEF, 8'hC3}) begin
      bad++; $display("FAIL store_fields: got we=%0b re=%0b a=%0h wd=%0h want we=1 re=0 a=beef wd=c3", mem_we, mem_re, mem_addr, mem_wdata);
    end
  endtask

  task automatic test_squash_stall();
    idle(); ex_valid = 1; ex_jump = 1; ex_br_cond = 2'b00; ex_br_target = 16'h0ABC;
    step();
    total++;
    if ({br_taken, br_target} !== {1'b1, 16'h0ABC}) begin
      bad++; $display("FAIL always_taken: got br=%0b tgt=%0h want br=1 tgt=0abc", br_taken, br_target);
    end
    idle();
    step();
    total++;
    if ({br_taken, flush_out, mem_valid} !== 3'b000) begin
      bad++; $display("FAIL pulse_width: got br=%0b fl=%0b v=%0b want 000", br_taken, flush_out, mem_valid);
    end
    step();
    idle(); ex_valid = 1; alu_dout = 8'h11; ex_wb_en = 1;
    step();
    total++;
    if (mem_valid !== 1'b0) begin bad++; $display("FAIL gap_drop: got v=%0b want 0", mem_valid); end
    idle(); ex_valid = 1; alu_dout = 8'h22; ex_wb_en = 1;
    step();
    total++;
    if ({mem_valid, mem_dout} !== {1'b1, 8'h22}) begin
      bad++; $display("FAIL gap_next: got v=%0b d=%0h want v=1 d=22", mem_valid, mem_dout);
    end
  endtask

  task automatic test_reset_mid();
    idle(); ex_valid = 1; ex_jump = 1; ex_br_cond = 2'b00; ex_br_target = 16'h0F0F;
    ex_cmp = 1; comp_lt = 1;
    step();
    mem_ready = 0; idle();
    #2 rst_n = 0;
    #1;
    total++;
    if ({br_taken, flush_out, br_target, flag_c, flag_gt, flag_lt, flag_eq, mem_valid, mem_dout} !== '0) begin
      bad++; $display("FAIL async_reset: got br=%0b tgt=%0h flags=%b%b%b%b v=%0b want zero", br_taken, br_target, flag_c, flag_gt, flag_lt, flag_eq, mem_valid);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1; mem_ready = 1;
    #1;
    total++;
    if (ex_ready !== 1'b1) begin bad++; $display("FAIL post_reset_ready: got %0b want 1", ex_ready); end
    ex_valid = 1; alu_dout = 8'h66;
    step();
    total++;
    if ({mem_valid, mem_dout, br_taken} !== {1'b1, 8'h66, 1'b0}) begin
      bad++; $display("FAIL post_reset_accept: got v=%0b d=%0h br=%0b want v=1 d=66 br=0", mem_valid, mem_dout, br_taken);
    end
  endtask

  initial begin
    test_reset();
    test_cmp_branch();
    test_same_cycle();
    test_backpressure();
    test_carry_fwd();
    test_squash_stall();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pl_exmem_stage.md
Name: pl_exmem_stage

Overview:
- EX/MEM boundary stage directly downstream of the EX-stage ALU; consumes ALU result, carry and compare outputs plus the decoded control fields travelling with the instruction.
- Holds the architectural status flags (C, GT, LT, EQ) and resolves jumps and conditional branches against them.
- Registers the instruction into the MEM stage under a valid/ready handshake, issues a branch-taken flush to IF/ID, and provides a forwarding tap back to EX.

Parameters:
- DATA_W, 8, ALU/data width.
- ADDR_W, 16, data-memory and branch-target address width.
- RD_W, 3, destination register index width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ex_valid  in  1  EX holds a valid instruction.
- ex_ready  out  1  stage can accept this cycle.
- alu_dout  in  DATA_W  ALU result.
- alu_cout  in  1  ALU carry out.
- comp_gt, comp_lt, comp_eq  in  1 each  ALU compare outputs.
- ex_upd_c  in  1  instruction updates C (add/shift).
- ex_cmp  in  1  compare instruction; updates GT/LT/EQ.
- ex_jump  in  1  jump/branch instruction.
- ex_br_cond  in  2  00 always, 01 EQ, 10 GT, 11 LT.
- ex_br_target  in  ADDR_W  branch target.
- ex_wb_en, ex_mem_we, ex_mem_re  in  1 each  writeback, store, load.
- ex_rd  in  RD_W  destination register.
- ex_mem_addr  in  ADDR_W  memory address.
- ex_store_data  in  DATA_W  store data.
- mem_ready  in  1  MEM stage accepts.
- mem_valid  out  1  MEM-side instruction valid.
- mem_dout, mem_wdata  out  DATA_W  registered ALU result, store data.
- mem_addr  out  ADDR_W  registered address.
- mem_we, mem_re, mem_wb_en  out  1 each  registered controls.
- mem_rd  out  RD_W  registered destination.
- flag_c, flag_gt, flag_lt, flag_eq  out  1 each  status flag register.
- br_taken  out  1  one-cycle taken pulse.
- br_target  out  ADDR_W  target, valid while br_taken.
- flush_out  out  1  flush IF/ID; identical to br_taken.
- fwd_valid  out  1  mem_valid AND mem_wb_en.
- fwd_rd  out  RD_W  equals mem_rd.
- fwd_data  out  DATA_W  equals mem_dout.

Behaviour:
- Reset (async, rst_n low): every registered output is 0, including the flags, br_taken, br_target and squash_pending. ex_ready = 1 on release.
- ex_ready = !mem_valid || mem_ready (combinational).
- Handshake: hs = ex_valid && ex_ready.
  - acc = hs && !squash_pending.
  - drop = hs && squash_pending.
- Stall (mem_valid && !mem_ready): all mem_* outputs hold stable, flags hold, no acc.
- Register update on acc, latency 1 cycle:
  - mem_valid <= !ex_jump. A jump becomes a bubble.
  - All mem_* fields load from the ex_* and alu_* inputs.
- On hs without acc, or on mem_ready with no acc: mem_valid <= 0.
- Flags, on acc only:
  - ex_upd_c: flag_c <= alu_cout.
  - ex_cmp: {gt,lt,eq} <= {comp_gt,comp_lt,comp_eq}.
  - Both may happen in one cycle. Each flag group is otherwise held.
- Branch resolution on acc && ex_jump:
  - The condition uses the flag register value before this cycle's update; a same-cycle flag update is not visible to it.
  - Taken: br_taken and flush_out pulse high for exactly the next cycle, br_target <= ex_br_target, squash_pending <= 1.
  - Not taken: no pulse and no effect beyond the bubble.
- Squash: squash_pending clears on the first drop. The dropped instruction updates no flags, reaches no MEM state and cannot branch.
- A drop and a new taken branch cannot coincide.
- br_target is held after the pulse; only its value during br_taken is meaningful.
- A stall during squash_pending leaves squash_pending set until a handshake occurs.
- Reset mid-operation: in-flight MEM instruction, pending squash and flags are all lost; no br_taken is emitted.

Decomposition:
- Shared package pl_pkg:
  - BR_ALWAYS/BR_EQ/BR_GT/BR_LT 2-bit encodings.
  - DATA_W/ADDR_W/RD_W defaults.
  - Flag-vector bit indices (C=3, GT=2, LT=1, EQ=0).
- One natural sub-module: pl_branch_cond, combinational; takes cond and the 4 flags, outputs taken.
- Flag register and pipeline register stay in the top.

Test Plan:
- Compare then branch: cmp with comp_gt=1 accepted, next jump cond=10 target 0x1234 → br_taken/flush_out high 1 cycle, br_target=0x1234. Following ex instruction dropped: no mem_valid, flags unchanged.
- Same-cycle hazard: flags EQ=0; instruction with ex_cmp=1, comp_eq=1 and ex_jump=1 cond=01 → not taken; flag_eq=1 the next cycle.
- Backpressure: mem_valid=1, mem_ready=0 for 3 cycles with ex_valid=1, alu_dout=0x5A → ex_ready=0, outputs stable. mem_ready rises → 0x5A accepted the next cycle.
- Carry/forward: add with alu_cout=1, alu_dout=0xFF, wb_en=1, rd=5 → flag_c=1, fwd_valid=1, fwd_rd=5, fwd_data=0xFF.
- Squash across a stall: taken branch, then ex_valid=0 for 2 cycles, then instruction 0x11 → 0x11 dropped, and the next instruction 0x22 reaches mem_dout.
- Async reset mid-stall with squash pending → all outputs 0 immediately, ex_ready=1 after release, the first instruction is accepted.
